// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt sequencer between MEM and CP0.
//
// Picks the highest-priority event presented by the MEM stage (interrupt,
// invalid inst, syscall, trap, overflow, eret), kills the MEM instruction in
// the same cycle, then issues a one-cycle registered excepttype pulse with
// the faulting PC and delay-slot flag. The same cycle flushes the pipeline
// and redirects fetch. After the flush, all events are ignored for
// HOLD_CYCLES cycles while CP0 EXL settles.
//
// Optional feature: define EXC_TIMER_INT_EN to add timer_int_i. It is OR-ed
// into IP7 (cause_i[15]) before the interrupt mask is applied.
//
// Parameters:
//   EXC_VECTOR   redirect PC for every exception and interrupt
//   HOLD_CYCLES  post-flush blackout length, legal range 1..15
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   mem_valid_i      MEM stage holds a real instruction
//   mem_exc_i        [0] syscall [1] invalid [2] overflow [3] trap [4] eret
//   mem_pc_i         PC of the MEM instruction
//   mem_dslot_i      MEM instruction sits in a delay slot
//   stall_i          pipeline stalled (defers interrupts only)
//   status_i         forwarded CP0 Status
//   cause_i          forwarded CP0 Cause
//   epc_i            forwarded CP0 EPC (eret target)
//   timer_int_i      (EXC_TIMER_INT_EN only) extra IP7 source
//   mem_kill_o       combinational, suppresses MEM writeback on acceptance
//   excepttype_o     registered one-cycle code pulse to CP0
//   exc_pc_o         current_inst_addr for CP0
//   exc_dslot_o      is_in_delay_slot for CP0
//   flush_o          clears all pipeline registers
//   new_pc_o         fetch redirect target, valid while flush_o=1
// -----------------------------------------------------------------------------
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [4:0]  mem_exc_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_dslot_i,
    input  logic        stall_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
`ifdef EXC_TIMER_INT_EN
    input  logic        timer_int_i,
`endif
    output logic        mem_kill_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_dslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [31:0] CODE_INT  = 32'h0000_0001;
    localparam logic [31:0] CODE_INV  = 32'h0000_000a;
    localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
    localparam logic [31:0] CODE_TRAP = 32'h0000_000d;
    localparam logic [31:0] CODE_OV   = 32'h0000_000c;
    localparam logic [31:0] CODE_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  hold_cnt_q;
    logic [31:0] excepttype_q;
    logic [31:0] exc_pc_q;
    logic        exc_dslot_q;
    logic        flush_q;
    logic [31:0] new_pc_q;

    logic [7:0]  ip_eff;
    logic        int_pend;
    logic        sync_evt;
    logic        int_evt;
    logic        accept;
    logic [31:0] code_d;
    logic [31:0] new_pc_d;

    // Status/Cause bits outside the interrupt fields are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

`ifdef EXC_TIMER_INT_EN
    assign ip_eff = {cause_i[15] | timer_int_i, cause_i[14:8]};
`else
    assign ip_eff = cause_i[15:8];
`endif

    // IE set, EXL clear, and at least one unmasked pending line.
    assign int_pend = status_i[0] & ~status_i[1] & |(ip_eff & status_i[15:8]);

    // Synchronous exceptions must be taken even while stalled; interrupts
    // wait for a real, moving instruction to attach the EPC to.
    assign sync_evt = mem_valid_i & |mem_exc_i;
    assign int_evt  = mem_valid_i & int_pend & ~stall_i;
    assign accept   = (state_q == IDLE) & (sync_evt | int_evt);

    assign mem_kill_o = accept;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        code_d = '0;
        if (int_evt)           code_d = CODE_INT;
        else if (mem_exc_i[1]) code_d = CODE_INV;
        else if (mem_exc_i[0]) code_d = CODE_SYS;
        else if (mem_exc_i[3]) code_d = CODE_TRAP;
        else if (mem_exc_i[2]) code_d = CODE_OV;
        else if (mem_exc_i[4]) code_d = CODE_ERET;

        // Fetch targets are word aligned; drop any stray low bits of EPC.
        new_pc_d = (code_d == CODE_ERET) ? epc_i : EXC_VECTOR;
        new_pc_d = new_pc_d & 32'hffff_fffc;
    end

    // NOTE: state and outputs are registered with non-blocking assignments
    // so every read in this block sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            excepttype_q <= '0;
            exc_pc_q     <= '0;
            exc_dslot_q  <= 1'b0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
        end else begin
            // Pulses are low unless the acceptance branch below raises them.
            excepttype_q <= '0;
            flush_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= FLUSH;
                        excepttype_q <= code_d;
                        exc_pc_q     <= mem_pc_i;
                        exc_dslot_q  <= mem_dslot_i;
                        flush_q      <= 1'b1;
                        new_pc_q     <= new_pc_d;
                    end
                end
                FLUSH: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= 4'(HOLD_CYCLES - 1);
                end
                HOLD: begin
                    if (hold_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign excepttype_o = excepttype_q;
    assign exc_pc_o     = exc_pc_q;
    assign exc_dslot_o  = exc_dslot_q;
    assign flush_o      = flush_q;
    assign new_pc_o     = new_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl -- self-checking bench for exc_ctrl.
//
// A cycle-indexed model tracks when the next acceptance is allowed and what
// the registered outputs must show; a table gives the event priority. Directed
// scenarios pin literal values; a randomized run exercises the rest.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

    localparam int          HOLD = 2;
    localparam logic [31:0] VEC  = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic [4:0]  mem_exc_i;
    logic [31:0] mem_pc_i;
    logic        mem_dslot_i;
    logic        stall_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
`ifdef EXC_TIMER_INT_EN
    logic        timer_int_i;
`endif
    logic        mem_kill_o;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_dslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    exc_ctrl #(
        .EXC_VECTOR  (VEC),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid_i  (mem_valid_i),
        .mem_exc_i    (mem_exc_i),
        .mem_pc_i     (mem_pc_i),
        .mem_dslot_i  (mem_dslot_i),
        .stall_i      (stall_i),
        .status_i     (status_i),
        .cause_i      (cause_i),
        .epc_i        (epc_i),
`ifdef EXC_TIMER_INT_EN
        .timer_int_i  (timer_int_i),
`endif
        .mem_kill_o   (mem_kill_o),
        .excepttype_o (excepttype_o),
        .exc_pc_o     (exc_pc_o),
        .exc_dslot_o  (exc_dslot_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Model state
    int          cyc;
    int          next_ok;     // first cycle index an event may be accepted
    logic [31:0] e_type;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_dslot;
    logic [31:0] e_newpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Priority table, highest first after the interrupt: mem_exc bit -> code.
    function automatic logic [31:0] code_of(input logic [4:0] exc, input bit int_ok);
        int          bits  [5] = '{1, 0, 3, 2, 4};
        logic [31:0] codes [5] = '{32'ha, 32'h8, 32'hd, 32'hc, 32'he};
        if (int_ok) return 32'h1;
        for (int i = 0; i < 5; i++)
            if (exc[bits[i]]) return codes[i];
        return 32'h0;
    endfunction

    // One clock cycle: compare at the falling edge, advance the model,
    // return 1 time unit after the rising edge.
    task automatic tick();
        bit          pend;
        bit          int_ok;
        bit          kill_exp;
        logic [7:0]  ip;
        logic [31:0] code;
        @(negedge clk);
        ip = cause_i[15:8];
`ifdef EXC_TIMER_INT_EN
        ip[7] = ip[7] | timer_int_i;
`endif
        pend     = status_i[0] && !status_i[1] && ((ip & status_i[15:8]) != 8'h0);
        int_ok   = mem_valid_i && pend && !stall_i;
        kill_exp = (cyc >= next_ok) && mem_valid_i && ((mem_exc_i != 5'h0) || int_ok);
        if (!rst) check("mem_kill", 32'(mem_kill_o), 32'(kill_exp));
        check("excepttype", excepttype_o, e_type);
        check("flush", 32'(flush_o), 32'(e_flush));
        if (e_flush) begin
            check("exc_pc", exc_pc_o, e_pc);
            check("exc_dslot", 32'(exc_dslot_o), 32'(e_dslot));
            check("new_pc", new_pc_o, e_newpc);
        end else if (cyc < next_ok) begin
            check("new_pc_hold", new_pc_o, e_newpc);
        end

        if (rst) begin
            e_type = '0; e_flush = 1'b0; e_pc = '0; e_dslot = 1'b0; e_newpc = '0;
            next_ok = cyc + 1;
        end else if (kill_exp) begin
            code    = code_of(mem_exc_i, int_ok);
            e_type  = code;
            e_flush = 1'b1;
            e_pc    = mem_pc_i;
            e_dslot = mem_dslot_i;
            e_newpc = ((code == 32'he) ? epc_i : VEC) & 32'hffff_fffc;
            next_ok = cyc + 2 + HOLD;
        end else begin
            e_type  = '0;
            e_flush = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        mem_valid_i = 1'b0;
        mem_exc_i   = '0;
        mem_pc_i    = '0;
        mem_dslot_i = 1'b0;
        stall_i     = 1'b0;
        status_i    = '0;
        cause_i     = '0;
        epc_i       = '0;
`ifdef EXC_TIMER_INT_EN
        timer_int_i = 1'b0;
`endif
    endtask

    task automatic present(input logic [4:0] exc, input logic [31:0] pc, input logic dslot);
        mem_valid_i = 1'b1;
        mem_exc_i   = exc;
        mem_pc_i    = pc;
        mem_dslot_i = dslot;
    endtask

    task automatic drain(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        cyc = 0; next_ok = 0;
        e_type = '0; e_flush = 1'b0; e_pc = '0; e_dslot = 1'b0; e_newpc = '0;
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;

        // Reset state
        check("rst_excepttype", excepttype_o, 32'h0);
        check("rst_exc_pc", exc_pc_o, 32'h0);
        check("rst_dslot", 32'(exc_dslot_o), 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_new_pc", new_pc_o, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Syscall
        present(5'b00001, 32'h100, 1'b0);
        #1;
        check("sys_kill_T", 32'(mem_kill_o), 32'h1);
        tick();
        set_idle();
        check("sys_type_T1", excepttype_o, 32'h8);
        check("sys_pc_T1", exc_pc_o, 32'h100);
        check("sys_flush_T1", 32'(flush_o), 32'h1);
        check("sys_newpc_T1", new_pc_o, 32'h20);
        tick();
        check("sys_type_T2", excepttype_o, 32'h0);
        check("sys_flush_T2", 32'(flush_o), 32'h0);
        drain(3);

        // Priority: invalid inst wins, lower bits dropped
        present(5'b10111, 32'h140, 1'b1);
        tick();
        set_idle();
        check("prio_type", excepttype_o, 32'ha);
        check("prio_dslot", 32'(exc_dslot_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prio_no_more", excepttype_o, 32'h0);
        end

        // Interrupt gated by stall, then taken
        present(5'b00000, 32'h180, 1'b0);
        status_i = 32'h0000_0401;
        cause_i  = 32'h0000_0400;
        stall_i  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("int_stall_noflush", 32'(flush_o), 32'h0);
        stall_i = 1'b0;
        tick();
        set_idle();
        check("int_type", excepttype_o, 32'h1);
        check("int_pc", exc_pc_o, 32'h180);
        drain(3);

        // Interrupt with EXL set is never accepted
        present(5'b00000, 32'h1c0, 1'b0);
        status_i = 32'h0000_0403;
        cause_i  = 32'h0000_0400;
        for (int i = 0; i < 5; i++) begin
            stall_i = (i < 2);
            tick();
            check("int_exl_noflush", 32'(flush_o), 32'h0);
        end
        drain(1);

        // ERET
        present(5'b10000, 32'h1f0, 1'b0);
        epc_i = 32'h2000_0040;
        tick();
        set_idle();
        check("eret_type", excepttype_o, 32'he);
        check("eret_newpc", new_pc_o, 32'h2000_0040);
        drain(3);

        // Holdoff: events at T+1..T+3 ignored, T+4 accepted
        present(5'b00001, 32'h200, 1'b0);
        tick();                                    // T
        present(5'b00001, 32'h300, 1'b0);
        check("hold_type_T1", excepttype_o, 32'h8);
        check("hold_pc_T1", exc_pc_o, 32'h200);
        tick();                                    // T+1
        check("hold_flush_T2", 32'(flush_o), 32'h0);
        tick();                                    // T+2
        check("hold_flush_T3", 32'(flush_o), 32'h0);
        tick();                                    // T+3
        check("hold_flush_T4", 32'(flush_o), 32'h0);
        present(5'b00001, 32'h400, 1'b0);
        #1;
        check("hold_kill_T4", 32'(mem_kill_o), 32'h1);
        tick();                                    // T+4
        set_idle();
        check("hold_type_T5", excepttype_o, 32'h8);
        check("hold_pc_T5", exc_pc_o, 32'h400);
        drain(3);

        // Reset during FLUSH
        present(5'b00001, 32'h500, 1'b1);
        tick();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_type", excepttype_o, 32'h0);
        check("rstmid_flush", 32'(flush_o), 32'h0);
        check("rstmid_pc", exc_pc_o, 32'h0);
        check("rstmid_dslot", 32'(exc_dslot_o), 32'h0);
        check("rstmid_newpc", new_pc_o, 32'h0);
        tick();
        present(5'b00001, 32'h600, 1'b0);
        tick();
        set_idle();
        check("rstmid_after_type", excepttype_o, 32'h8);
        check("rstmid_after_pc", exc_pc_o, 32'h600);
        drain(3);

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            mem_valid_i = ($urandom_range(0, 3) != 0);
            mem_exc_i   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
            mem_pc_i    = $urandom;
            mem_dslot_i = 1'($urandom);
            stall_i     = ($urandom_range(0, 3) == 0);
            status_i    = $urandom;
            status_i[0] = ($urandom_range(0, 3) != 0);
            status_i[1] = ($urandom_range(0, 5) == 0);
            cause_i     = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            epc_i       = $urandom;
            tick();
        end
        rst = 1'b0;
        drain(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
